pc_sequencer: RTL and testbench

- Parametrised program-counter unit for the pipelined MIPS core.
- Generalises the fixed PC+4 adder: holds the fetch PC register and produces PC+STEP.
- Selects the next PC from sequential fetch, branch/jump redirect, exception vector and ERET return.
- Honours stalls. A redirect that arrives while stalled is buffered and applied on the first unstalled cycle.

---
 rtl/pc_sequencer.sv | 88 ++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch program counter: sequential PC+STEP, redirect, exception and ERET selection,
// with a one-entry buffer that holds a redirect seen during a stall until the stall clears.
module pc_sequencer #(
    parameter int                WIDTH      = 32,
    parameter int                STEP       = 4,
    parameter logic [WIDTH-1:0]  RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0]  EXC_VECTOR = 32'h0000_4180,
    parameter int                ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             pc_misaligned,
    output logic             pending_valid
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Exceptions and ERET bypass the stall; everything else waits for it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        if (exc_valid) begin
            pc_d    = EXC_VECTOR;
            state_d = IDLE;
        end else if (eret_valid) begin
            pc_d    = epc;
            state_d = IDLE;
        end else if (stall) begin
            if (redirect_valid) begin
                pend_tgt_d = redirect_target;
                state_d    = PENDING;
            end
        end else if (redirect_valid) begin
            pc_d    = redirect_target;
            state_d = IDLE;
        end else if (state_q == PENDING) begin
            pc_d    = pend_tgt_q;
            state_d = IDLE;
        end else begin
            pc_d = pc_q + STEP_W;
        end
    end

    always_comb begin
        pc            = pc_q;
        pc_plus_step  = pc_q + STEP_W;
        pending_valid = (state_q == PENDING);
    end

    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign pc_misaligned = |pc_q[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign pc_misaligned = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected PC state is queued per driven cycle and
// compared by an independent monitor shortly after each rising edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus_step;
    logic        pc_misaligned;
    logic        pending_valid;

    logic [15:0] pc16;
    logic [15:0] ps16;
    logic        mis16;
    logic        pv16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pv;
        logic        chk16;
        logic [15:0] pc16;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .eret_valid      (eret_valid),
        .epc             (epc),
        .pc              (pc),
        .pc_plus_step    (pc_plus_step),
        .pc_misaligned   (pc_misaligned),
        .pending_valid   (pending_valid)
    );

    // Narrow instance starting just below the top of its address space to exercise wrap.
    pc_sequencer #(
        .WIDTH      (16),
        .STEP       (2),
        .RESET_PC   (16'hFFFC),
        .EXC_VECTOR (16'h0180),
        .ALIGN_BITS (1)
    ) dut16 (
        .clk             (clk),
        .reset           (reset),
        .stall           (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (16'h0000),
        .exc_valid       (1'b0),
        .eret_valid      (1'b0),
        .epc             (16'h0000),
        .pc              (pc16),
        .pc_plus_step    (ps16),
        .pc_misaligned   (mis16),
        .pending_valid   (pv16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus_step", pc_plus_step, e.pc + 32'd4);
            chk("pc_misaligned", {31'd0, pc_misaligned}, {31'd0, (e.pc[1:0] != 2'b00)});
            chk("pending_valid", {31'd0, pending_valid}, {31'd0, e.pv});
            if (e.chk16) begin
                chk("pc16", {16'd0, pc16}, {16'd0, e.pc16});
                chk("pc_plus_step16", {16'd0, ps16}, {16'd0, 16'(e.pc16 + 16'd2)});
                chk("pc_misaligned16", {31'd0, mis16}, {31'd0, e.pc16[0]});
                chk("pending_valid16", {31'd0, pv16}, 32'd0);
            end
        end
    end

    task automatic step(input logic rst, input logic stl, input logic rv, input logic [31:0] rt,
                        input logic ex, input logic er, input logic [31:0] ep,
                        input logic [31:0] exp_pc, input logic exp_pv,
                        input logic c16 = 1'b0, input logic [15:0] exp16 = 16'h0);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = rt;
        exc_valid       = ex;
        eret_valid      = er;
        epc             = ep;
        e.pc    = exp_pc;
        e.pv    = exp_pv;
        e.chk16 = c16;
        e.pc16  = exp16;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        exc_valid = 1'b0; eret_valid = 1'b0; epc = '0;
        //   rst   stl   rv    target        exc   eret  epc           pc            pv
        step(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3000, 1'b0, 1'b1, 16'hFFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3004, 1'b0, 1'b1, 16'hFFFE);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3008, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3008, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3008, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3008, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_300C, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3010, 1'b0);
        // Redirect buffered while stalled, applied on release.
        step(1'b0, 1'b1, 1'b1, 32'h3100,     1'b0, 1'b0, 32'h0,        32'h0000_3010, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3010, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3010, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3100, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3104, 1'b0);
        // Exception during stall drops the pending redirect; ERET returns.
        step(1'b0, 1'b1, 1'b1, 32'h3100,     1'b0, 1'b0, 32'h0,        32'h0000_3104, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0000_4180, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h3020,     32'h0000_3020, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h3020,     32'h0000_4180, 1'b0);
        // Live redirect beats buffered one, and the buffer does not resurface.
        step(1'b0, 1'b1, 1'b1, 32'h3100,     1'b0, 1'b0, 32'h0,        32'h0000_4180, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h3200,     1'b0, 1'b0, 32'h0,        32'h0000_3200, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3204, 1'b0);
        // Reset with a pending redirect.
        step(1'b0, 1'b1, 1'b1, 32'h3100,     1'b0, 1'b0, 32'h0,        32'h0000_3204, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3004, 1'b0);
        // Wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,       32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0);
        // Misaligned target is carried forward, not corrected.
        step(1'b0, 1'b0, 1'b1, 32'h3002,     1'b0, 1'b0, 32'h0,        32'h0000_3002, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3006, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_300A, 1'b0);
        // Second redirect in the same stall overwrites the buffer.
        step(1'b0, 1'b1, 1'b1, 32'h3300,     1'b0, 1'b0, 32'h0,        32'h0000_300A, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h3400,     1'b0, 1'b0, 32'h0,        32'h0000_300A, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3400, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3404, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
